// File: rtl/multicycle_datapath.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB processor datapath; opcode 5 is BNE when MULTICYCLE_BNE_EN is defined, illegal otherwise.
// Latency FETCH-to-FETCH with zero wait states: BEQ/BNE/illegal 3, SW/R-type/ADDI 4, LW 5; HALT retires in DECODE.
// Backpressure: FETCH holds im_req and MEM holds dm_req until the matching ready; nothing else stalls.
module multicycle_datapath #(
    parameter int WIDTH    = 24,
    parameter int PC_RESET = 10,
    parameter int PC_STEP  = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    output logic             im_req,
    output logic [WIDTH-1:0] im_addr,
    input  logic [WIDTH-1:0] im_rdata,
    input  logic             im_ready,
    output logic             dm_req,
    output logic             dm_we,
    output logic [WIDTH-1:0] dm_addr,
    output logic [WIDTH-1:0] dm_wdata,
    input  logic [WIDTH-1:0] dm_rdata,
    input  logic             dm_ready,
    output logic [WIDTH-1:0] pc,
    output logic             halted,
    output logic             retire,
    output logic             illegal,
    input  logic [3:0]       dbg_raddr,
    output logic [WIDTH-1:0] dbg_rdata
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_BNE   = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [WIDTH-1:0] STEP   = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] PC_RST = WIDTH'(PC_RESET);

    state_t           r_state, w_state_nxt;
    logic             r_run;
    logic [WIDTH-1:0] r_pc, w_pc_nxt;
    logic [WIDTH-1:0] r_ir, r_a, r_b, r_imm, r_alu, r_mdr;
    logic [WIDTH-1:0] r_regs [16];

    logic [3:0]       w_op, w_rs, w_rt, w_rd, w_funct;
    logic [WIDTH-1:0] w_imm_ext, w_alu, w_wb_dat;
    logic [3:0]       w_wb_idx;
    logic             w_is_bne, w_is_branch, w_taken, w_known, w_illegal_op;

    assign w_op      = r_ir[WIDTH-1 -: 4];
    assign w_rs      = r_ir[WIDTH-5 -: 4];
    assign w_rt      = r_ir[WIDTH-9 -: 4];
    assign w_rd      = r_ir[WIDTH-13 -: 4];
    assign w_funct   = r_ir[3:0];
    assign w_imm_ext = {{12{r_ir[WIDTH-13]}}, r_ir[WIDTH-13:0]};

`ifdef MULTICYCLE_BNE_EN
    assign w_is_bne = (w_op == OP_BNE);
`else
    assign w_is_bne = 1'b0;
`endif

    // r_a/r_b hold the operands latched in DECODE, so the compare is stable in EXEC
    assign w_is_branch  = (w_op == OP_BEQ) || w_is_bne;
    assign w_taken      = ((w_op == OP_BEQ) && (r_a == r_b)) || (w_is_bne && (r_a != r_b));
    assign w_known      = (w_op == OP_RTYPE) || (w_op == OP_ADDI) || (w_op == OP_LW) ||
                          (w_op == OP_SW) || w_is_branch;
    assign w_illegal_op = !w_known;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    4'd0:    w_alu = r_a + r_b;
                    4'd1:    w_alu = r_a - r_b;
                    4'd2:    w_alu = r_a & r_b;
                    4'd3:    w_alu = r_a | r_b;
                    4'd4:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                    default: w_alu = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: w_alu = r_a + r_imm;
            default:               w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            FETCH: begin
                if (im_req && im_ready) w_state_nxt = DECODE;
            end
            DECODE: begin
                w_state_nxt = (w_op == OP_HALT) ? HALT : EXEC;
            end
            EXEC: begin
                if ((w_op == OP_RTYPE) || (w_op == OP_ADDI)) begin
                    w_state_nxt = WB;
                end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
                    w_state_nxt = MEM;
                end else begin
                    w_state_nxt = FETCH;
                    w_pc_nxt    = w_taken ? (r_pc + STEP + r_imm) : (r_pc + STEP);
                end
            end
            MEM: begin
                if (dm_ready) begin
                    if (w_op == OP_SW) begin
                        w_state_nxt = FETCH;
                        w_pc_nxt    = r_pc + STEP;
                    end else begin
                        w_state_nxt = WB;
                    end
                end
            end
            WB: begin
                w_state_nxt = FETCH;
                w_pc_nxt    = r_pc + STEP;
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    // r_run keeps requests low for the first cycle after any reset edge
    assign im_req   = (r_state == FETCH) && r_run;
    assign im_addr  = im_req ? r_pc : '0;
    assign dm_req   = (r_state == MEM);
    assign dm_we    = dm_req && (w_op == OP_SW);
    assign dm_addr  = dm_req ? r_alu : '0;
    assign dm_wdata = dm_we ? r_b : '0;

    assign pc      = r_pc;
    assign halted  = (r_state == HALT);
    assign illegal = (r_state == EXEC) && w_illegal_op;
    assign retire  = ((r_state == DECODE) && (w_op == OP_HALT)) ||
                     ((r_state == EXEC) && (w_is_branch || w_illegal_op)) ||
                     (dm_we && dm_ready) ||
                     (r_state == WB);

    assign w_wb_idx  = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_wb_dat  = (w_op == OP_LW) ? r_mdr : r_alu;
    assign dbg_rdata = (dbg_raddr == 4'd0) ? '0 : r_regs[dbg_raddr];

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= FETCH;
            r_run   <= 1'b0;
            r_pc    <= PC_RST;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            r_pc    <= w_pc_nxt;
            if (im_req && im_ready) r_ir <= im_rdata;
            if (r_state == DECODE) begin
                r_a   <= r_regs[w_rs];
                r_b   <= r_regs[w_rt];
                r_imm <= w_imm_ext;
            end
            if (r_state == EXEC) r_alu <= w_alu;
            if (dm_req && dm_ready && (w_op == OP_LW)) r_mdr <= dm_rdata;
            if ((r_state == WB) && (w_wb_idx != 4'd0)) r_regs[w_wb_idx] <= w_wb_dat;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed program run on multicycle_datapath with instruction/data memory models and a latency/pc scoreboard.
module tb_multicycle_datapath;
    localparam int W = 24;

`ifdef MULTICYCLE_BNE_EN
    localparam int OP5_PC  = 67;
    localparam int OP5_ILL = 0;
`else
    localparam int OP5_PC  = 61;
    localparam int OP5_ILL = 1;
`endif

    logic         Clock = 1'b0;
    logic         Reset_n = 1'b0;
    logic         im_req, im_ready, dm_req, dm_we, dm_ready;
    logic [W-1:0] im_addr, im_rdata, dm_addr, dm_wdata, dm_rdata, pc, dbg_rdata;
    logic         halted, retire, illegal;
    logic [3:0]   dbg_raddr = 4'd0;

    multicycle_datapath #(.WIDTH(W), .PC_RESET(10), .PC_STEP(3)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ready(im_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .pc(pc), .halted(halted), .retire(retire), .illegal(illegal),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 Clock = ~Clock;

    logic [W-1:0] imem [0:255];
    logic [W-1:0] dmem [0:255];
    int im_delay = 0, dm_delay = 0, icnt = 0, dcnt = 0;

    assign im_ready = im_req && (icnt >= im_delay);
    assign dm_ready = dm_req && (dcnt >= dm_delay);
    assign im_rdata = imem[im_addr[7:0]];
    assign dm_rdata = dmem[dm_addr[7:0]];

    always @(posedge Clock) begin
        icnt <= (im_req && !im_ready) ? icnt + 1 : 0;
        dcnt <= (dm_req && !dm_ready) ? dcnt + 1 : 0;
        if (dm_req && dm_we && dm_ready) dmem[dm_addr[7:0]] <= dm_wdata;
    end

    int n_cmp = 0, n_err = 0;
    int n_overlap = 0, n_leak = 0, n_ill = 0;
    bit mon_en = 1'b0;

    always @(negedge Clock) begin
        if (mon_en && im_req && dm_req) n_overlap++;
        if (mon_en && !dm_req && (dm_we || dm_addr != '0 || dm_wdata != '0)) n_leak++;
        if (mon_en && illegal) n_ill++;
    end

    typedef struct {
        string        tag;
        int           lat;
        logic [W-1:0] pc;
    } exp_t;
    exp_t sb[$];
    int   last_dmc;

    function automatic logic [W-1:0] enc_i(input logic [3:0] op, input logic [3:0] rs,
                                           input logic [3:0] rt, input logic [11:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [W-1:0] enc_r(input logic [3:0] rs, input logic [3:0] rt,
                                           input logic [3:0] rd, input logic [3:0] f);
        return {4'd0, rs, rt, rd, 4'd0, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [W-1:0] exp);
        dbg_raddr = idx;
        #1;
        chk(tag, 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    // Counts cycles from the first im_req of an instruction up to and including its retire pulse
    task automatic run_instr(output int cyc, output int dmc, output bit to);
        int t = 0;
        cyc = 0; dmc = 0; to = 1'b0;
        while (!im_req && t < 50) begin
            @(negedge Clock);
            t++;
        end
        if (!im_req) begin
            to = 1'b1;
            return;
        end
        cyc = 1;
        while (1) begin
            if (dm_req) dmc++;
            if (retire) break;
            if (cyc >= 50) begin
                to = 1'b1;
                break;
            end
            @(negedge Clock);
            cyc++;
        end
    endtask

    task automatic step(input string tag, input int lat, input int pc_exp);
        exp_t e;
        int   cyc, dmc;
        bit   to;
        sb.push_back('{tag, lat, W'(pc_exp)});
        run_instr(cyc, dmc, to);
        e = sb.pop_front();
        last_dmc = dmc;
        chk({e.tag, "_timeout"}, 32'(to), 32'd0);
        chk({e.tag, "_lat"}, 32'(cyc), 32'(e.lat));
        @(negedge Clock);
        chk({e.tag, "_pc"}, 32'(pc), 32'(e.pc));
    endtask

    initial begin
        int ill0, t, n_imreq, n_ret;
        for (int i = 0; i < 256; i++) imem[i] = 24'hF00000;
        imem[10] = enc_i(4'd1, 4'd0, 4'd1, 12'd5);
        imem[13] = enc_i(4'd1, 4'd0, 4'd1, 12'd7);
        imem[16] = enc_i(4'd1, 4'd0, 4'd2, 12'd7);
        imem[19] = enc_i(4'd4, 4'd1, 4'd2, 12'd6);
        imem[28] = enc_i(4'd4, 4'd1, 4'd2, 12'hFFD);
        imem[31] = enc_i(4'd3, 4'd0, 4'd1, 12'd100);
        imem[34] = enc_i(4'd2, 4'd0, 4'd3, 12'd100);
        imem[37] = enc_i(4'd1, 4'd0, 4'd1, 12'hFFF);
        imem[40] = enc_i(4'd1, 4'd0, 4'd2, 12'd1);
        imem[43] = enc_r(4'd1, 4'd2, 4'd3, 4'd0);
        imem[46] = enc_r(4'd1, 4'd2, 4'd5, 4'd4);
        imem[49] = enc_r(4'd2, 4'd1, 4'd6, 4'd1);
        imem[52] = enc_r(4'd6, 4'd2, 4'd7, 4'd3);
        imem[55] = enc_i(4'd1, 4'd0, 4'd0, 12'd9);
        imem[58] = enc_i(4'd5, 4'd1, 4'd2, 12'd6);

        do_reset();
        chk("rst_pc", 32'(pc), 32'd10);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_imreq", 32'(im_req), 32'd0);
        chk("rst_dmreq", 32'(dm_req), 32'd0);

        step("addi_r1_5", 4, 13);
        chk_reg("r1_5", 4'd1, 24'd5);
        step("addi_r1_7", 4, 16);
        im_delay = 2;
        step("addi_r2_wait", 6, 19);
        im_delay = 0;
        chk_reg("r2_7", 4'd2, 24'd7);
        step("beq_fwd", 3, 28);
        step("beq_loop1", 3, 28);
        step("beq_loop2", 3, 28);
        imem[28] = enc_i(4'd4, 4'd1, 4'd0, 12'd0);
        step("beq_nt", 3, 31);
        step("sw", 4, 34);
        chk("sw_mem", 32'(dmem[100]), 32'd7);
        dm_delay = 3;
        step("lw_wait", 8, 37);
        dm_delay = 0;
        chk("lw_dmreq_cycles", 32'(last_dmc), 32'd4);
        chk_reg("r3_lw", 4'd3, 24'd7);
        step("addi_m1", 4, 40);
        step("addi_1", 4, 43);
        step("add_wrap", 4, 46);
        chk_reg("r3_add_wrap", 4'd3, 24'd0);
        step("slt", 4, 49);
        chk_reg("r5_slt", 4'd5, 24'd1);
        step("sub", 4, 52);
        chk_reg("r6_sub", 4'd6, 24'd2);
        step("or", 4, 55);
        chk_reg("r7_or", 4'd7, 24'd3);
        step("addi_r0", 4, 58);
        chk_reg("r0_zero", 4'd0, 24'd0);
        ill0 = n_ill;
        step("op5", 3, OP5_PC);
        chk("op5_illegal", 32'(n_ill - ill0), 32'(OP5_ILL));
        step("halt", 2, OP5_PC);
        chk("halted", 32'(halted), 32'd1);
        n_imreq = 0; n_ret = 0;
        for (int i = 0; i < 20; i++) begin
            if (im_req) n_imreq++;
            if (retire) n_ret++;
            @(negedge Clock);
        end
        chk("halt_imreq", 32'(n_imreq), 32'd0);
        chk("halt_retire", 32'(n_ret), 32'd0);
        chk("halt_pc", 32'(pc), 32'(OP5_PC));

        imem[10] = enc_i(4'd2, 4'd0, 4'd3, 12'd100);
        dm_delay = 10;
        do_reset();
        t = 0;
        while (!dm_req && t < 30) begin
            @(negedge Clock);
            t++;
        end
        chk("mid_lw_dmreq_seen", 32'(dm_req), 32'd1);
        @(negedge Clock);
        Reset_n = 1'b0;
        @(negedge Clock);
        chk("mid_rst_dmreq", 32'(dm_req), 32'd0);
        chk("mid_rst_imreq", 32'(im_req), 32'd0);
        Reset_n = 1'b1;
        chk("mid_rst_pc", 32'(pc), 32'd10);
        chk("mid_rst_halted", 32'(halted), 32'd0);
        chk_reg("mid_rst_r1", 4'd1, 24'd0);
        chk_reg("mid_rst_r3", 4'd3, 24'd0);
        dm_delay = 0;

        chk("no_req_overlap", 32'(n_overlap), 32'd0);
        chk("dm_bus_idle_zero", 32'(n_leak), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
